alu_operand_loader: RTL
=======================

// Module: alu_operand_loader
// PURPOSE
//  Upstream operand sequencer for the ALU/divider datapath. Takes shared switches and one raw push button.
//  Each debounced press captures, in turn, operand A, operand B and the opcode. It then presents them
//  stably, raises a one-cycle start pulse and flags a divide-by-zero request before the ALU consumes the operands.
// PARAMETERS
//  M          4       operand width (matches ALU/divider M)
//  OPW        4       opcode width
//  DEB_CYCLES 4       consecutive stable cycles required to accept a button level change (>=1)
//  DIV_OP     4'b0011 opcode value selecting division
// PORTS
//  clk    in   1    system clock, rising edge
//  rst    in   1    asynchronous reset, active-high
//  sw     in   M    operand switches (synchronous to clk)
//  op_sw  in   OPW  opcode switches (synchronous to clk)
//  btn    in   1    raw push button, asynchronous, bouncing
//  clr    in   1    synchronous clear, active-high
//  A      out  M    registered operand A
//  B      out  M    registered operand B
//  op     out  OPW  registered opcode
//  stage  out  2    FSM state: 00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 READY
//  valid  out  1    high while in READY (A, B, op stable and complete)
//  start  out  1    one-cycle pulse, first cycle of READY
//  div0   out  1    valid && op==DIV_OP && B==0
// BEHAVIOUR
//  Reset (async, rst=1): A=B=op=0, stage=LOAD_A, valid=start=div0=0, sync flops=0, debounced level=0, counter=0.
//  Input path: btn -> 2-flop synchroniser -> btn_s.
//  Debounce: counter clears when btn_s==deb. While btn_s!=deb it increments each cycle.
//   When btn_s!=deb and counter==DEB_CYCLES-1: deb<=btn_s, counter<=0.
//   A glitch shorter than DEB_CYCLES cycles never changes deb.
//  press = deb & ~deb_d (deb_d = deb delayed 1 cycle). Exactly one press per accepted rising level; release makes no press.
//  Latency: first clk edge sampling btn=1 is edge 1; deb rises at edge DEB_CYCLES+2; FSM acts at edge DEB_CYCLES+3.
//  FSM, evaluated on each edge where press=1:
//   LOAD_A : A<=sw, ->LOAD_B
//   LOAD_B : B<=sw, ->LOAD_OP
//   LOAD_OP: op<=op_sw, ->READY
//   READY  : A<=sw, ->LOAD_B. Starts a new operation; B and op keep their old values until overwritten.
//  No press: state and all operand registers hold.
//  start=1 only on the first cycle after entering READY; never two consecutive cycles.
//  valid follows stage==READY combinationally from the state register.
//  div0 is combinational from registered values; 0 outside READY.
//  clr=1: A=B=op=0, stage=LOAD_A on that edge.
//   clr has priority over a simultaneous press; that press is discarded.
//   clr does not touch the debounce path, so a still-held button produces no further press.
//  rst asserted mid-sequence: immediate return to reset values; partially loaded operands are lost.
//  sw/op_sw changes outside a capture edge have no effect on A/B/op.
// TESTING
//  Reset: rst=1 while btn toggles -> all outputs 0, stage=00; release rst, no press -> outputs unchanged.
//  Full load (DEB_CYCLES=4): sw=4'h9 press, sw=4'h2 press, op_sw=4'h3 press ->
//   A=9, B=2, op=3, stage=11, valid=1, start high exactly 1 cycle, div0=0; each capture 7 edges after btn rise.
//  Bounce: btn pulses of 1,2,3 cycles with 3-cycle gaps, then held 10 cycles ->
//   exactly one capture, no capture from short pulses.
//  Div-by-zero: load A=5, B=0, op=DIV_OP -> div0=1 in READY. Then load A=5, B=0, op=4'h1 -> div0=0.
//  Re-arm: in READY with sw=4'hF, press -> A=F, stage=01, valid=0, B/op retain previous values.
//  Clear collisions: clr coincident with the press edge in LOAD_OP -> stage=00, op=0, no start.
//   rst pulse mid-LOAD_B -> immediate reset values.

Source files
------------

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
//  Operand sequencer in front of the ALU/divider. One raw push button is
//  synchronised and debounced. Each accepted press captures, in turn,
//  operand A (from sw), operand B (from sw) and the opcode (from op_sw).
//  Once all three are held the block presents them stably, raises a
//  one-cycle start pulse and flags a divide-by-zero request.
//
//  Ports
//   clk    in   rising-edge system clock
//   rst    in   asynchronous reset, active-high
//   sw     in   [M-1:0]   operand switches (synchronous to clk)
//   op_sw  in   [OPW-1:0] opcode switches (synchronous to clk)
//   btn    in   raw, asynchronous, bouncing push button
//   clr    in   synchronous clear, active-high (operands + FSM only)
//   A, B   out  [M-1:0]   registered operands
//   op     out  [OPW-1:0] registered opcode
//   stage  out  [1:0]     00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 READY
//   valid  out  high while in READY
//   start  out  one-cycle pulse on the first cycle of READY
//   div0   out  valid && op==DIV_OP && B==0
// ---------------------------------------------------------------------------
module alu_operand_loader #(
  parameter int              M          = 4,
  parameter int              OPW        = 4,
  parameter int              DEB_CYCLES = 4,
  parameter logic [OPW-1:0]  DIV_OP     = 4'b0011
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   sw,
  input  logic [OPW-1:0] op_sw,
  input  logic           btn,
  input  logic           clr,
  output logic [M-1:0]   A,
  output logic [M-1:0]   B,
  output logic [OPW-1:0] op,
  output logic [1:0]     stage,
  output logic           valid,
  output logic           start,
  output logic           div0
);

  // Counter only has to reach DEB_CYCLES-1; +1 keeps width >= 1 for DEB_CYCLES=1.
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'b00,
    S_LOAD_B  = 2'b01,
    S_LOAD_OP = 2'b10,
    S_READY   = 2'b11
  } state_t;

  logic          r_sync1, r_sync2;
  logic          r_deb, r_deb_d;
  logic [CW-1:0] r_cnt;
  state_t        r_state, w_state_nxt;
  logic [M-1:0]  r_a, r_b;
  logic [OPW-1:0] r_op;
  logic          r_start;
  logic          w_press;
  logic          w_enter_ready;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: a level change is accepted only after it has been seen for
  // DEB_CYCLES consecutive cycles; any return to the old level restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_deb_d <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_press = r_deb & ~r_deb_d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD_A;
    else     r_state <= w_state_nxt;
  end

  // Next state; clr wins over a coincident press.
  always_comb begin
    w_state_nxt   = r_state;
    w_enter_ready = 1'b0;
    if (clr) begin
      w_state_nxt = S_LOAD_A;
    end else if (w_press) begin
      case (r_state)
        S_LOAD_A:  w_state_nxt = S_LOAD_B;
        S_LOAD_B:  w_state_nxt = S_LOAD_OP;
        S_LOAD_OP: begin
          w_state_nxt   = S_READY;
          w_enter_ready = 1'b1;
        end
        S_READY:   w_state_nxt = S_LOAD_B;
        default:   w_state_nxt = S_LOAD_A;
      endcase
    end
  end

  // Operand capture. READY re-arms by loading A straight away; B and op keep
  // their previous values until the following presses overwrite them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_enter_ready;
      if (clr) begin
        r_a  <= '0;
        r_b  <= '0;
        r_op <= '0;
      end else if (w_press) begin
        case (r_state)
          S_LOAD_A:  r_a  <= sw;
          S_LOAD_B:  r_b  <= sw;
          S_LOAD_OP: r_op <= op_sw;
          S_READY:   r_a  <= sw;
          default:   ;
        endcase
      end
    end
  end

  assign A     = r_a;
  assign B     = r_b;
  assign op    = r_op;
  assign stage = r_state;
  assign valid = (r_state == S_READY);
  assign start = r_start;
  assign div0  = valid && (r_op == DIV_OP) && (r_b == '0);

endmodule
